// File: rtl/rtc_host.sv
// rtc_host: processor-side command controller for the real-time clock.
//
// Accepts CPU commands on a valid/ready handshake. Each command is
// range-checked, issued to the RTC as a single-cycle rtc_on pulse, and
// answered on a valid/ready response channel. A shadow copy of the RTC alarm
// slots lets overflowing or duplicate alarms be rejected before issue. The
// RTC alarm level is edge-detected into a sticky, clearable irq.
//
// Optional build macro: RTC_HOST_READBACK_EN
//   When defined, a write or add/sub is followed by one READBACK cycle
//   (rtc_on=1, operation=00). The updated time is then returned in rsp_data.
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only in IDLE)
//   cmd_op[1:0]                    00 read, 01 write, 10 alarm, 11 add/sub
//   cmd_data[31:0]                 {sec,min,hr,day,yr}; bit5 = add(1)/sub(0)
//   rsp_valid/rsp_ready            response handshake
//   rsp_data[31:0], rsp_err        read result / command rejected
//   rtc_on, operation, w_data      RTC operation interface (registered)
//   r_data[31:0]                   RTC read data
//   alarm_intrpt                   RTC alarm level
//   irq, irq_clr                   sticky alarm interrupt and its clear

module rtc_host #(
  parameter int unsigned NUM_ALARMS    = 4,
  parameter int unsigned DAYS_PER_YEAR = 365
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        rtc_on,
  output logic [1:0]  operation,
  output logic [31:0] w_data,
  input  logic [31:0] r_data,
  input  logic        alarm_intrpt,
  output logic        irq,
  input  logic        irq_clr
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEY_W  = 17;
  localparam int unsigned CNT_W  = $clog2(NUM_ALARMS + 1);
  localparam int unsigned DAY_W  = 9;

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_ALARM  = 2'b10;
  localparam logic [1:0] OP_ADDSUB = 2'b11;

`ifdef RTC_HOST_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_RESP, S_READBACK
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_CHECK, S_ISSUE, S_RESP
  } state_t;
`endif

  state_t state_q, state_nxt;

  logic [1:0]        op_q,        op_nxt;
  logic [DATA_W-1:0] data_q,      data_nxt;
  logic [CNT_W-1:0]  alarm_cnt_q, alarm_cnt_nxt;
  logic [KEY_W-1:0]  shadow_q [NUM_ALARMS];
  logic              shadow_we;
  logic              alarm_prev_q;

  logic              cmd_ready_nxt;
  logic              rsp_valid_nxt;
  logic [DATA_W-1:0] rsp_data_nxt;
  logic              rsp_err_nxt;
  logic              rtc_on_nxt;
  logic [1:0]        operation_nxt;
  logic [DATA_W-1:0] w_data_nxt;

  logic [KEY_W-1:0]  key_c;
  logic              range_ok_c;
  logic              dup_c;
  logic              full_c;
  logic              cmd_ok_c;

  // Field bounds on the latched word; add/sub deltas share the same bounds.
  always_comb begin
    range_ok_c = (data_q[31:26] < 6'd60) &&
                 (data_q[25:20] < 6'd60) &&
                 (data_q[19:15] < 5'd24) &&
                 (data_q[14:6]  < DAY_W'(DAYS_PER_YEAR));
  end

  // Alarm key {sec,min,hr} compared against the occupied shadow slots only.
  always_comb begin
    key_c  = data_q[31:15];
    full_c = (alarm_cnt_q == CNT_W'(NUM_ALARMS));
    dup_c  = 1'b0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if ((CNT_W'(i) < alarm_cnt_q) && (shadow_q[i] == key_c)) begin
        dup_c = 1'b1;
      end
    end
  end

  always_comb begin
    case (op_q)
      OP_READ:  cmd_ok_c = 1'b1;
      OP_ALARM: cmd_ok_c = range_ok_c && !full_c && !dup_c;
      default:  cmd_ok_c = range_ok_c;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_nxt     = state_q;
    op_nxt        = op_q;
    data_nxt      = data_q;
    alarm_cnt_nxt = alarm_cnt_q;
    shadow_we     = 1'b0;
    rsp_data_nxt  = rsp_data;
    rsp_err_nxt   = rsp_err;
    rtc_on_nxt    = 1'b0;
    operation_nxt = OP_READ;
    w_data_nxt    = '0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_nxt    = cmd_op;
          data_nxt  = cmd_data;
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cmd_ok_c) begin
          state_nxt = S_ISSUE;
        end else begin
          rsp_err_nxt = 1'b1;
          state_nxt   = S_RESP;
        end
      end
      S_ISSUE: begin
        state_nxt = S_RESP;
        if (op_q == OP_READ) begin
          rsp_data_nxt = r_data;
        end
        if (op_q == OP_ALARM) begin
          shadow_we     = 1'b1;
          alarm_cnt_nxt = alarm_cnt_q + CNT_W'(1);
        end
`ifdef RTC_HOST_READBACK_EN
        if ((op_q == OP_WRITE) || (op_q == OP_ADDSUB)) begin
          state_nxt = S_READBACK;
        end
`endif
      end
`ifdef RTC_HOST_READBACK_EN
      S_READBACK: begin
        rsp_data_nxt = r_data;
        state_nxt    = S_RESP;
      end
`endif
      S_RESP: begin
        if (rsp_ready) begin
          rsp_err_nxt  = 1'b0;
          rsp_data_nxt = '0;
          state_nxt    = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // RTC interface is registered from the next state, so it is high exactly
    // for the ISSUE cycle and otherwise drives zeros.
    if (state_nxt == S_ISSUE) begin
      rtc_on_nxt    = 1'b1;
      operation_nxt = op_q;
      w_data_nxt    = data_q;
    end
`ifdef RTC_HOST_READBACK_EN
    if (state_nxt == S_READBACK) begin
      rtc_on_nxt    = 1'b1;
      operation_nxt = OP_READ;
    end
`endif

    cmd_ready_nxt = (state_nxt == S_IDLE);
    rsp_valid_nxt = (state_nxt == S_RESP);
  end

  // Command latch, shadow table and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q        <= OP_READ;
      data_q      <= '0;
      alarm_cnt_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        shadow_q[i] <= '0;
      end
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      rtc_on      <= 1'b0;
      operation   <= OP_READ;
      w_data      <= '0;
    end else begin
      op_q        <= op_nxt;
      data_q      <= data_nxt;
      alarm_cnt_q <= alarm_cnt_nxt;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (shadow_we && (CNT_W'(i) == alarm_cnt_q)) begin
          shadow_q[i] <= key_c;
        end
      end
      cmd_ready   <= cmd_ready_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
      rsp_err     <= rsp_err_nxt;
      rtc_on      <= rtc_on_nxt;
      operation   <= operation_nxt;
      w_data      <= w_data_nxt;
    end
  end

  // Sticky alarm interrupt on the rising edge of alarm_intrpt; set beats clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alarm_prev_q <= 1'b0;
      irq          <= 1'b0;
    end else begin
      alarm_prev_q <= alarm_intrpt;
      if (alarm_intrpt && !alarm_prev_q) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rtc_host.sv
// Directed self-checking bench for rtc_host. The RTC side is modelled as a
// constant r_data source; expected values are hand-computed constants.
module tb_rtc_host;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rtc_on;
  logic [1:0]  operation;
  logic [31:0] w_data;
  logic [31:0] r_data;
  logic        alarm_intrpt;
  logic        irq;
  logic        irq_clr;

  int checks;
  int errors;

  localparam logic [31:0] RD_VAL = 32'h0C30_8041;

`ifdef RTC_HOST_READBACK_EN
  localparam int          WR_LAT    = 4;
  localparam int          WR_PULSES = 2;
  localparam logic [31:0] WR_RDATA  = RD_VAL;
`else
  localparam int          WR_LAT    = 3;
  localparam int          WR_PULSES = 1;
  localparam logic [31:0] WR_RDATA  = 32'h0;
`endif

  rtc_host dut (
    .clk          (clk),
    .resetn       (resetn),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .rtc_on       (rtc_on),
    .operation    (operation),
    .w_data       (w_data),
    .r_data       (r_data),
    .alarm_intrpt (alarm_intrpt),
    .irq          (irq),
    .irq_clr      (irq_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one command and follow it until rsp_valid (bounded). lat counts
  // cycles after the handshake cycle; on_at is the cycle rtc_on first rose.
  task automatic do_cmd(input logic [1:0] op, input logic [31:0] data,
                        output logic err, output logic [31:0] rdata,
                        output int lat, output int pulses, output int on_at,
                        output logic [1:0] iop, output logic [31:0] iwd);
    bit first;
    first  = 1'b1;
    pulses = 0;
    on_at  = 0;
    iop    = 2'b00;
    iwd    = 32'h0;
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 32'h0;
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      if (rtc_on) begin
        pulses++;
        if (first) begin
          first = 1'b0;
          on_at = lat;
          iop   = operation;
          iwd   = w_data;
        end
      end
      if (rsp_valid) break;
      tick();
      lat++;
    end
    if (!rsp_valid) lat = 99;
    err   = rsp_err;
    rdata = rsp_data;
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %0b exp 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rtc_on !== 1'b0) begin errors++; $display("FAIL reset_rtc_on got %0b exp 0", rtc_on); end
    checks++; if (operation !== 2'b00) begin errors++; $display("FAIL reset_operation got %0b exp 00", operation); end
    checks++; if (w_data !== 32'h0) begin errors++; $display("FAIL reset_w_data got %h exp 0", w_data); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got %h exp 0", rsp_data); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %0b exp 0", rsp_err); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b exp 0", irq); end
  endtask

  task automatic test_read;
    logic err; logic [31:0] rd; int lat, pulses, on_at; logic [1:0] iop; logic [31:0] iwd;
    do_cmd(2'b00, 32'h0, err, rd, lat, pulses, on_at, iop, iwd);
    checks++; if (on_at !== 2) begin errors++; $display("FAIL read_on_cycle got %0d exp 2", on_at); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL read_pulses got %0d exp 1", pulses); end
    checks++; if (iop !== 2'b00) begin errors++; $display("FAIL read_operation got %0b exp 00", iop); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency got %0d exp 3", lat); end
    checks++; if (rd !== RD_VAL) begin errors++; $display("FAIL read_data got %h exp %h", rd, RD_VAL); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err got %0b exp 0", err); end
    release_rsp();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_clear got %0b exp 0", rsp_valid); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL read_data_clear got %h exp 0", rsp_data); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL read_ready_back got %0b exp 1", cmd_ready); end
  endtask

  task automatic test_write;
    logic [31:0] vec [6];
    logic        exp_err [6];
    logic err; logic [31:0] rd; int lat, pulses, on_at; logic [1:0] iop; logic [31:0] iwd;
    vec[0] = {6'd59, 6'd59, 5'd23, 9'd364, 6'd0};  exp_err[0] = 1'b0;
    vec[1] = {6'd60, 6'd0,  5'd0,  9'd0,   6'd0};  exp_err[1] = 1'b1;
    vec[2] = {6'd0,  6'd60, 5'd0,  9'd0,   6'd0};  exp_err[2] = 1'b1;
    vec[3] = {6'd0,  6'd0,  5'd24, 9'd0,   6'd0};  exp_err[3] = 1'b1;
    vec[4] = {6'd0,  6'd0,  5'd0,  9'd365, 6'd0};  exp_err[4] = 1'b1;
    vec[5] = {6'd1,  6'd2,  5'd3,  9'd4,   6'd63}; exp_err[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_cmd(2'b01, vec[i], err, rd, lat, pulses, on_at, iop, iwd);
      checks++; if (err !== exp_err[i]) begin errors++; $display("FAIL write%0d_err got %0b exp %0b", i, err, exp_err[i]); end
      if (exp_err[i]) begin
        checks++; if (lat !== 2) begin errors++; $display("FAIL write%0d_err_latency got %0d exp 2", i, lat); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL write%0d_err_pulses got %0d exp 0", i, pulses); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL write%0d_err_data got %h exp 0", i, rd); end
      end else begin
        checks++; if (lat !== WR_LAT) begin errors++; $display("FAIL write%0d_latency got %0d exp %0d", i, lat, WR_LAT); end
        checks++; if (pulses !== WR_PULSES) begin errors++; $display("FAIL write%0d_pulses got %0d exp %0d", i, pulses, WR_PULSES); end
        checks++; if (iop !== 2'b01) begin errors++; $display("FAIL write%0d_operation got %0b exp 01", i, iop); end
        checks++; if (iwd !== vec[i]) begin errors++; $display("FAIL write%0d_w_data got %h exp %h", i, iwd, vec[i]); end
        checks++; if (rd !== WR_RDATA) begin errors++; $display("FAIL write%0d_rsp_data got %h exp %h", i, rd, WR_RDATA); end
      end
      release_rsp();
    end
  endtask

  task automatic test_alarm;
    logic [31:0] vec [7];
    logic        exp_err [7];
    logic err; logic [31:0] rd; int lat, pulses, on_at; logic [1:0] iop; logic [31:0] iwd;
    vec[0] = {6'd0, 6'd0, 5'd1,  9'd0, 6'd0}; exp_err[0] = 1'b0;
    vec[1] = {6'd0, 6'd0, 5'd1,  9'd5, 6'd0}; exp_err[1] = 1'b1;
    vec[2] = {6'd0, 6'd0, 5'd24, 9'd0, 6'd0}; exp_err[2] = 1'b1;
    vec[3] = {6'd0, 6'd0, 5'd2,  9'd0, 6'd0}; exp_err[3] = 1'b0;
    vec[4] = {6'd0, 6'd0, 5'd3,  9'd0, 6'd0}; exp_err[4] = 1'b0;
    vec[5] = {6'd0, 6'd0, 5'd4,  9'd0, 6'd0}; exp_err[5] = 1'b0;
    vec[6] = {6'd0, 6'd0, 5'd5,  9'd0, 6'd0}; exp_err[6] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      do_cmd(2'b10, vec[i], err, rd, lat, pulses, on_at, iop, iwd);
      checks++; if (err !== exp_err[i]) begin errors++; $display("FAIL alarm%0d_err got %0b exp %0b", i, err, exp_err[i]); end
      if (exp_err[i]) begin
        checks++; if (pulses !== 0) begin errors++; $display("FAIL alarm%0d_err_pulses got %0d exp 0", i, pulses); end
      end else begin
        checks++; if (pulses !== 1) begin errors++; $display("FAIL alarm%0d_pulses got %0d exp 1", i, pulses); end
        checks++; if (iop !== 2'b10) begin errors++; $display("FAIL alarm%0d_operation got %0b exp 10", i, iop); end
        checks++; if (iwd !== vec[i]) begin errors++; $display("FAIL alarm%0d_w_data got %h exp %h", i, iwd, vec[i]); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL alarm%0d_latency got %0d exp 3", i, lat); end
      end
      release_rsp();
    end
  endtask

  task automatic test_addsub;
    logic [31:0] d;
    logic err; logic [31:0] rd; int lat, pulses, on_at; logic [1:0] iop; logic [31:0] iwd;
    d = {6'd30, 6'd0, 5'd0, 9'd0, 6'b100000};
    do_cmd(2'b11, d, err, rd, lat, pulses, on_at, iop, iwd);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL add_err got %0b exp 0", err); end
    checks++; if (pulses !== WR_PULSES) begin errors++; $display("FAIL add_pulses got %0d exp %0d", pulses, WR_PULSES); end
    checks++; if (on_at !== 2) begin errors++; $display("FAIL add_on_cycle got %0d exp 2", on_at); end
    checks++; if (iop !== 2'b11) begin errors++; $display("FAIL add_operation got %0b exp 11", iop); end
    checks++; if (iwd !== d) begin errors++; $display("FAIL add_w_data got %h exp %h", iwd, d); end
    checks++; if (lat !== WR_LAT) begin errors++; $display("FAIL add_latency got %0d exp %0d", lat, WR_LAT); end
    checks++; if (rd !== WR_RDATA) begin errors++; $display("FAIL add_rsp_data got %h exp %h", rd, WR_RDATA); end
    release_rsp();
    checks++; if (rtc_on !== 1'b0) begin errors++; $display("FAIL add_rtc_off got %0b exp 0", rtc_on); end
    d = {6'd60, 6'd0, 5'd0, 9'd0, 6'b100000};
    do_cmd(2'b11, d, err, rd, lat, pulses, on_at, iop, iwd);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL add_bad_err got %0b exp 1", err); end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL add_bad_pulses got %0d exp 0", pulses); end
    release_rsp();
    d = {6'd0, 6'd0, 5'd0, 9'd10, 6'b000000};
    do_cmd(2'b11, d, err, rd, lat, pulses, on_at, iop, iwd);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sub_err got %0b exp 0", err); end
    checks++; if (iwd !== d) begin errors++; $display("FAIL sub_w_data got %h exp %h", iwd, d); end
    release_rsp();
  endtask

  task automatic test_backpressure;
    logic err; logic [31:0] rd; int lat, pulses, on_at; logic [1:0] iop; logic [31:0] iwd;
    do_cmd(2'b00, 32'h0, err, rd, lat, pulses, on_at, iop, iwd);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency got %0d exp 3", lat); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %0b exp 1", i, rsp_valid); end
      checks++; if (rsp_data !== RD_VAL) begin errors++; $display("FAIL bp_data%0d got %h exp %h", i, rsp_data, RD_VAL); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready%0d got %0b exp 0", i, cmd_ready); end
    end
    release_rsp();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %0b exp 0", rsp_valid); end
  endtask

  task automatic test_irq;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %0b exp 0", irq); end
    alarm_intrpt = 1'b1;
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %0b exp 1", irq); end
    for (int i = 0; i < 4; i++) tick();
    alarm_intrpt = 1'b0;
    tick();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_sticky got %0b exp 1", irq); end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %0b exp 0", irq); end
    alarm_intrpt = 1'b1;
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set_wins got %0b exp 1", irq); end
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear_hold got %0b exp 0", irq); end
    for (int i = 0; i < 3; i++) tick();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_level_no_reset got %0b exp 0", irq); end
    alarm_intrpt = 1'b0;
    tick();
    alarm_intrpt = 1'b1;
    tick();
    alarm_intrpt = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_second_edge got %0b exp 1", irq); end
  endtask

  task automatic test_reset_mid;
    logic err; logic [31:0] rd; int lat, pulses, on_at; logic [1:0] iop; logic [31:0] iwd;
    cmd_op    = 2'b01;
    cmd_data  = {6'd10, 6'd10, 5'd10, 9'd10, 6'd10};
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++; if (rtc_on !== 1'b1) begin errors++; $display("FAIL mid_issue got %0b exp 1", rtc_on); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (rtc_on !== 1'b0) begin errors++; $display("FAIL mid_rtc_on got %0b exp 0", rtc_on); end
    checks++; if (operation !== 2'b00) begin errors++; $display("FAIL mid_operation got %0b exp 00", operation); end
    checks++; if (w_data !== 32'h0) begin errors++; $display("FAIL mid_w_data got %h exp 0", w_data); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %0b exp 0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL mid_rsp_err got %0b exp 0", rsp_err); end
    checks++; if (rsp_data !== 32'h0) begin errors++; $display("FAIL mid_rsp_data got %h exp 0", rsp_data); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL mid_irq got %0b exp 0", irq); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready got %0b exp 1", cmd_ready); end
    cmd_op   = 2'b00;
    cmd_data = 32'h0;
    #2 resetn = 1'b1;
    tick();
    // Shadow table was full before reset; the first alarm key is free again.
    do_cmd(2'b10, {6'd0, 6'd0, 5'd1, 9'd0, 6'd0}, err, rd, lat, pulses, on_at, iop, iwd);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_alarm_after_reset got %0b exp 0", err); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL mid_alarm_pulses got %0d exp 1", pulses); end
    release_rsp();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    resetn       = 1'b0;
    cmd_valid    = 1'b0;
    cmd_op       = 2'b00;
    cmd_data     = 32'h0;
    rsp_ready    = 1'b0;
    r_data       = RD_VAL;
    alarm_intrpt = 1'b0;
    irq_clr      = 1'b0;
    #12;
    test_reset();
    tick();
    resetn = 1'b1;
    tick();
    test_read();
    test_write();
    test_alarm();
    test_addsub();
    test_backpressure();
    test_irq();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_host.md
Name: rtc_host

Overview:
- Processor-side command controller for the real-time clock: the initiator end of the RTC operation interface (rtc_on/operation/w_data/r_data/alarm_intrpt).
- Accepts CPU commands over a valid/ready handshake, range-checks time words, issues each RTC operation for exactly one clk cycle, and returns a response.
- Mirrors the RTC's alarm slots so that overflow and duplicate alarms are rejected before issue.
- Latches the RTC alarm level into a sticky, clearable interrupt.

Parameters:
- NUM_ALARMS, 4, alarm slots in the RTC; the shadow table depth (1..4).
- DAYS_PER_YEAR, 365, upper bound (exclusive) for the day field.

Ports:
- clk  in  1  system clock, shared with the RTC.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00=read, 01=write, 10=alarm, 11=add/sub.
- cmd_data  in  32  time word {sec[31:26],min[25:20],hr[19:15],day[14:6],yr[5:0]}; for add/sub, bit5=1 add / 0 subtract.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  read result, else 0.
- rsp_err  out  1  command rejected, no RTC operation issued.
- rtc_on  out  1  RTC operation enable.
- operation  out  2  RTC operation code.
- w_data  out  32  RTC write data.
- r_data  in  32  RTC read data, combinational while rtc_on=1 and operation=00.
- alarm_intrpt  in  1  RTC alarm level.
- irq  out  1  sticky alarm interrupt.
- irq_clr  in  1  clears irq.

Behaviour:
- Reset (async): state=IDLE, rtc_on=0, operation=00, w_data=0, rsp_valid=0, rsp_data=0, rsp_err=0, irq=0, alarm shadow cleared, alarm_cnt=0, alarm_prev=0.
- FSM states: IDLE, CHECK, ISSUE, RESP.
- IDLE: on cmd_valid&cmd_ready, latch op and data; go to CHECK.
- CHECK (1 cycle): validate the latched command.
  - Write/alarm: sec<60, min<60, hr<24, day<DAYS_PER_YEAR.
  - Add/sub: the same bounds apply to the delta fields.
  - Alarm: also reject if alarm_cnt==NUM_ALARMS, or if key cmd_data[31:15] matches any valid shadow entry.
  - Read: always valid.
  - Fail: rsp_err=1, go to RESP without touching the RTC. Pass: go to ISSUE.
- ISSUE (exactly 1 cycle): rtc_on=1, operation=op, w_data=latched data.
  - Read: capture r_data into rsp_data at the end of this cycle.
  - Alarm: write key to shadow[alarm_cnt], alarm_cnt+1.
  - rtc_on returns to 0 on the next cycle; never asserted for 2+ consecutive cycles per command, so add/sub is never applied twice.
- RESP: rsp_valid=1 with rsp_data/rsp_err stable; on rsp_ready go to IDLE, clearing rsp_valid, rsp_err and rsp_data.
- Latency: handshake at cycle N; rtc_on high at N+2; rsp_valid at N+3. Error path: rsp_valid at N+2.
- When rtc_on=0, operation and w_data are driven to 0.
- Shadow table is cleared only by reset, matching the RTC, which has no alarm delete.
- Interrupt:
  - alarm_prev registers alarm_intrpt each cycle.
  - A rising edge (alarm_intrpt & ~alarm_prev) sets irq.
  - irq_clr clears irq.
  - Simultaneous set and clear: set wins.
  - irq is independent of FSM state.
- Reset mid-operation: all state is abandoned, and rtc_on drops immediately (async).

Optional Feature:
- Macro RTC_HOST_READBACK_EN.
- When defined: after ISSUE of a write or add/sub, the FSM enters an extra READBACK state (1 cycle, rtc_on=1, operation=00), captures r_data, and returns the updated time in rsp_data. rsp_valid then arrives at N+4.
- When undefined: the READBACK state does not exist, and rsp_data=0 for all non-read commands.

Test Plan:
- Reset then read with RTC r_data=0x0C30_8041 -> rtc_on high exactly 1 cycle at N+2 with operation=00; rsp_valid at N+3, rsp_data=0x0C30_8041, rsp_err=0.
- Write with sec=60 (cmd_data[31:26]=6'd60) -> rsp_err=1 at N+2, rtc_on never asserted, shadow and alarm_cnt unchanged.
- Five alarms with distinct valid keys -> first four issue operation=10 with alarm_cnt 1..4; fifth gets rsp_err=1 and no rtc_on. A duplicate key on the second alarm -> rsp_err=1.
- Add/sub with cmd_data bit5=1, sec delta 30 -> rtc_on high exactly one cycle with w_data equal to cmd_data. With RTC_HOST_READBACK_EN, rsp_data equals the r_data presented in the READBACK cycle.
- alarm_intrpt held high 5 cycles -> irq set once. irq_clr in the rising-edge cycle of a second pulse -> irq stays 1. irq_clr alone -> irq=0 next cycle.
- rsp_ready held low 10 cycles -> rsp_valid and rsp_data stable, cmd_ready=0. resetn pulsed low during ISSUE -> rtc_on=0 immediately, all outputs at reset values.
